// File: rtl/seq_control_unit_if.sv
// ---------------------------------------------------------------------------
// seq_control_unit_if
// Purpose : bundles the fetch / data-memory handshakes and the datapath
//           control strobes of the sequencing control unit.
// Signals :
//   opCode    - instruction opcode, valid while fetchAck is high
//   fetchAck  - instruction available this cycle
//   memAck    - data-memory access completes this cycle
//   fetchReq  - instruction fetch request
//   irLoad    - instruction-register load strobe
//   pcInc     - program-counter increment strobe
//   memReq    - data-memory request
//   memWe     - data-memory write enable
//   regWrite  - register-file write enable
//   selOp     - ALU operation select
//   destSrc   - destination mux select
//   busy      - high whenever the unit is not in FETCH
//   illegalOp - sticky undefined-opcode flag
// Modports: master = the control unit, slave = the datapath/memory side.
// ---------------------------------------------------------------------------
interface seq_control_unit_if #(
  parameter int OP_W  = 4,
  parameter int SEL_W = 3
);
  logic [OP_W-1:0]  opCode;
  logic             fetchAck;
  logic             memAck;
  logic             fetchReq;
  logic             irLoad;
  logic             pcInc;
  logic             memReq;
  logic             memWe;
  logic             regWrite;
  logic [SEL_W-1:0] selOp;
  logic [1:0]       destSrc;
  logic             busy;
  logic             illegalOp;

  modport master (
    input  opCode, fetchAck, memAck,
    output fetchReq, irLoad, pcInc, memReq, memWe, regWrite,
           selOp, destSrc, busy, illegalOp
  );

  modport slave (
    output opCode, fetchAck, memAck,
    input  fetchReq, irLoad, pcInc, memReq, memWe, regWrite,
           selOp, destSrc, busy, illegalOp
  );
endinterface

// File: rtl/seq_control_unit.sv
// ---------------------------------------------------------------------------
// seq_control_unit
// Purpose : multi-cycle instruction sequencer. Walks each instruction through
//           FETCH -> DECODE -> EXEC -> (MEM) -> (WB) and drives the datapath
//           strobes as Moore outputs of the registered state and the latched
//           opcode (irLoad/pcInc are additionally qualified by fetchAck).
// Opcodes : 0 load, 1 move, 2 add, 3 sub, 4 and, 5 or, 6 xor, 7 store;
//           codes 8 and above are undefined.
// Ports   :
//   clk   - rising-edge clock
//   rstN  - asynchronous active-low reset (forces FETCH immediately)
//   bus   - seq_control_unit_if.master (handshakes and control strobes)
// Config  : define ILLEGAL_TRAP_EN to trap undefined opcodes in a HALT state
//           that only reset leaves; otherwise they execute as a NOP.
// ---------------------------------------------------------------------------
module seq_control_unit #(
  parameter int OP_W  = 4,
  parameter int SEL_W = 3
) (
  input  logic               clk,
  input  logic               rstN,
  seq_control_unit_if.master bus
);

  typedef enum logic [2:0] {
    S_FETCH,
    S_DECODE,
    S_EXEC,
    S_MEM,
    S_WB,
    S_HALT
  } state_e;

  state_e          state_q, state_d;
  logic [OP_W-1:0] op_q, op_d;

  logic       op_undef;
  logic [2:0] op_code;
  logic       is_load;
  logic       is_move;
  logic       is_alu;
  logic       is_store;

  logic             fetch_req;
  logic             ir_load;
  logic             pc_inc;
  logic             mem_req;
  logic             mem_we;
  logic             reg_write;
  logic [SEL_W-1:0] sel_op;
  logic [1:0]       dest_src;
  logic             busy;

  // Classify the latched opcode once; everything downstream keys off these.
  always_comb begin
    op_undef = (op_q > OP_W'(7));
    op_code  = op_q[2:0];
    is_load  = !op_undef && (op_code == 3'd0);
    is_move  = !op_undef && (op_code == 3'd1);
    is_alu   = !op_undef && (op_code >= 3'd2) && (op_code <= 3'd6);
    is_store = !op_undef && (op_code == 3'd7);
  end

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      state_q <= S_FETCH;
      op_q    <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
    end
  end

  // Next-state logic. Acks arriving in states that do not wait on them are
  // simply never looked at, so they have no effect.
  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    case (state_q)
      S_FETCH: begin
        if (bus.fetchAck) begin
          op_d    = bus.opCode;
          state_d = S_DECODE;
        end
      end
      S_DECODE: begin
        if (op_undef) begin
`ifdef ILLEGAL_TRAP_EN
          state_d = S_HALT;
`else
          state_d = S_FETCH;
`endif
        end else begin
          state_d = S_EXEC;
        end
      end
      S_EXEC: begin
        if (is_load || is_store) begin
          state_d = S_MEM;
        end else begin
          state_d = S_WB;
        end
      end
      S_MEM: begin
        // A store has nothing to write back, so it retires straight to FETCH.
        if (bus.memAck) begin
          state_d = is_store ? S_FETCH : S_WB;
        end
      end
      S_WB: begin
        state_d = S_FETCH;
      end
      S_HALT: begin
`ifdef ILLEGAL_TRAP_EN
        state_d = S_HALT;
`else
        state_d = S_FETCH;
`endif
      end
      default: begin
        state_d = S_FETCH;
      end
    endcase
  end

  // Output decode. irLoad/pcInc are also gated by rstN so that a fetchAck
  // present while reset is held cannot raise a strobe.
  always_comb begin
    fetch_req = (state_q == S_FETCH);
    ir_load   = fetch_req && bus.fetchAck && rstN;
    pc_inc    = fetch_req && bus.fetchAck && rstN;
    mem_req   = (state_q == S_MEM);
    mem_we    = (state_q == S_MEM) && is_store;
    reg_write = (state_q == S_WB);
    busy      = (state_q != S_FETCH);
    sel_op    = '0;
    if ((state_q == S_EXEC) && is_alu) begin
      // add..xor are opcodes 2..6 and map to selects 0..4.
      sel_op = SEL_W'(op_code - 3'd2);
    end
    dest_src = 2'b00;
    if (is_move) begin
      dest_src = 2'b01;
    end else if (is_alu) begin
      dest_src = 2'b10;
    end else if (is_store) begin
      dest_src = 2'b11;
    end
  end

  assign bus.fetchReq = fetch_req;
  assign bus.irLoad   = ir_load;
  assign bus.pcInc    = pc_inc;
  assign bus.memReq   = mem_req;
  assign bus.memWe    = mem_we;
  assign bus.regWrite = reg_write;
  assign bus.selOp    = sel_op;
  assign bus.destSrc  = dest_src;
  assign bus.busy     = busy;

`ifdef ILLEGAL_TRAP_EN
  // HALT is only left through reset, so decoding the flag from the state
  // makes it sticky until reset clears it.
  assign bus.illegalOp = (state_q == S_HALT);
`else
  assign bus.illegalOp = 1'b0;
`endif

endmodule

// File: tb/tb_seq_control_unit.sv
// ---------------------------------------------------------------------------
// tb_seq_control_unit
// Purpose : self-checking bench for seq_control_unit. A reference model turns
//           each instruction (opcode, fetch wait, memory wait) into the list
//           of per-cycle inputs and expected outputs; the bench plays that
//           list into the DUT and compares outputs at the falling edge.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_seq_control_unit;

  localparam int OP_W  = 4;
  localparam int SEL_W = 3;
`ifdef ILLEGAL_TRAP_EN
  localparam bit TRAP = 1'b1;
`else
  localparam bit TRAP = 1'b0;
`endif

  // Output vector: {fetchReq, irLoad, pcInc, memReq, memWe, regWrite,
  //                 busy, illegalOp, destSrc[1:0], selOp[2:0]}
  localparam logic [12:0] MASK_ALL = 13'h1FFF;
  localparam logic [12:0] MASK_NODEST = 13'h1FE7;

  typedef struct {
    logic            fa;
    logic [OP_W-1:0] op;
    logic            ma;
    logic [12:0]     exp;
    logic [12:0]     mask;
  } cyc_t;

  logic clk = 1'b0;
  logic rstN;

  cyc_t        q[$];
  cyc_t        doneQ[$];
  logic [12:0] obsQ[$];
  int          errors = 0;
  int          checks = 0;
  int          prevOp = 0;

  seq_control_unit_if #(.OP_W(OP_W), .SEL_W(SEL_W)) bus ();

  seq_control_unit #(.OP_W(OP_W), .SEL_W(SEL_W)) dut (
    .clk  (clk),
    .rstN (rstN),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  function automatic logic [12:0] pack_outputs();
    return {bus.fetchReq, bus.irLoad, bus.pcInc, bus.memReq, bus.memWe,
            bus.regWrite, bus.busy, bus.illegalOp, bus.destSrc, bus.selOp};
  endfunction

  function automatic logic [12:0] mk(logic fr, logic il, logic pc, logic mr,
                                     logic mw, logic rw, logic by, logic ill,
                                     logic [1:0] ds, logic [2:0] sel);
    return {fr, il, pc, mr, mw, rw, by, ill, ds, sel};
  endfunction

  // Destination select by instruction class; undefined opcodes have none.
  function automatic logic [1:0] dest_for(int op);
    if (op == 0) return 2'b00;
    if (op == 1) return 2'b01;
    if (op >= 2 && op <= 6) return 2'b10;
    if (op == 7) return 2'b11;
    return 2'b00;
  endfunction

  function automatic logic [12:0] mask_for(int op);
    return (op > 7) ? MASK_NODEST : MASK_ALL;
  endfunction

  task automatic push(logic fa, logic [OP_W-1:0] op, logic ma,
                      logic [12:0] exp, logic [12:0] mask);
    cyc_t c;
    c.fa = fa; c.op = op; c.ma = ma; c.exp = exp; c.mask = mask;
    q.push_back(c);
  endtask

  // Idle FETCH cycles: no fetchAck, random memAck that must be ignored.
  task automatic build_idle(int n);
    for (int i = 0; i < n; i++)
      push(1'b0, OP_W'($urandom), 1'($urandom),
           mk(1, 0, 0, 0, 0, 0, 0, 0, dest_for(prevOp), 3'd0), mask_for(prevOp));
  endtask

  // One instruction starting with its fetchAck cycle; memAck comes after
  // mw wait cycles in MEM. Acks outside their states are random noise.
  task automatic build_instr(int op, int mw);
    logic [1:0]  d;
    logic [12:0] m;
    logic [2:0]  sel;
    push(1'b1, OP_W'(op), 1'($urandom),
         mk(1, 1, 1, 0, 0, 0, 0, 0, dest_for(prevOp), 3'd0), mask_for(prevOp));
    prevOp = op;
    d = dest_for(op);
    m = mask_for(op);
    push(1'($urandom), OP_W'($urandom), 1'($urandom),
         mk(0, 0, 0, 0, 0, 0, 1, 0, d, 3'd0), m);
    if (op > 7) begin
      if (TRAP)
        for (int i = 0; i < 20; i++)
          push(1'($urandom), OP_W'($urandom), 1'($urandom),
               mk(0, 0, 0, 0, 0, 0, 1, 1, d, 3'd0), m);
      return;
    end
    sel = (op >= 2 && op <= 6) ? 3'(op - 2) : 3'd0;
    push(1'($urandom), OP_W'($urandom), 1'($urandom),
         mk(0, 0, 0, 0, 0, 0, 1, 0, d, sel), m);
    if (op == 0 || op == 7)
      for (int i = 0; i <= mw; i++)
        push(1'($urandom), OP_W'($urandom), (i == mw),
             mk(0, 0, 0, 1, (op == 7), 0, 1, 0, d, 3'd0), m);
    if (op != 7)
      push(1'($urandom), OP_W'($urandom), 1'($urandom),
           mk(0, 0, 0, 0, 0, 1, 1, 0, d, 3'd0), m);
  endtask

  // Plays up to limit queued cycles; entered and left just after a rising edge.
  task automatic run_queue(int limit);
    cyc_t c;
    int   n = 0;
    obsQ.delete();
    doneQ.delete();
    while (q.size() > 0 && n < limit) begin
      c = q.pop_front();
      bus.fetchAck = c.fa;
      bus.opCode   = c.op;
      bus.memAck   = c.ma;
      @(negedge clk);
      obsQ.push_back(pack_outputs());
      doneQ.push_back(c);
      @(posedge clk);
      #1;
      n++;
    end
    q.delete();
  endtask

  task automatic do_reset();
    bus.fetchAck = 1'b1;
    bus.memAck   = 1'b1;
    bus.opCode   = 4'h7;
    #2;
    rstN = 1'b0;
    #1;
    checks++;
    if (pack_outputs() !== mk(1, 0, 0, 0, 0, 0, 0, 0, 2'b00, 3'd0)) begin
      errors++;
      $display("[TB] FAIL reset_outputs: got %b expected %b", pack_outputs(),
               mk(1, 0, 0, 0, 0, 0, 0, 0, 2'b00, 3'd0));
    end
    @(negedge clk);
    rstN = 1'b1;
    bus.fetchAck = 1'b0;
    bus.memAck   = 1'b0;
    @(posedge clk);
    #1;
    prevOp = 0;
  endtask

  task automatic test_reset();
    rstN = 1'b1;
    bus.fetchAck = 1'b0;
    bus.memAck   = 1'b0;
    bus.opCode   = '0;
    #1;
    do_reset();
    build_idle(2);
    run_queue(1000);
    for (int i = 0; i < obsQ.size(); i++) begin
      checks++;
      if ((obsQ[i] & doneQ[i].mask) !== (doneQ[i].exp & doneQ[i].mask)) begin
        errors++;
        $display("[TB] FAIL post_reset cycle %0d: got %b expected %b", i, obsQ[i], doneQ[i].exp);
      end
    end
  endtask

  task automatic test_alu_sub();
    build_instr(3, 0);
    build_idle(1);
    run_queue(1000);
    for (int i = 0; i < obsQ.size(); i++) begin
      checks++;
      if ((obsQ[i] & doneQ[i].mask) !== (doneQ[i].exp & doneQ[i].mask)) begin
        errors++;
        $display("[TB] FAIL alu_sub cycle %0d: got %b expected %b", i, obsQ[i], doneQ[i].exp);
      end
    end
  endtask

  task automatic test_load_wait();
    build_instr(0, 3);
    build_idle(1);
    run_queue(1000);
    for (int i = 0; i < obsQ.size(); i++) begin
      checks++;
      if ((obsQ[i] & doneQ[i].mask) !== (doneQ[i].exp & doneQ[i].mask)) begin
        errors++;
        $display("[TB] FAIL load_wait cycle %0d: got %b expected %b", i, obsQ[i], doneQ[i].exp);
      end
    end
  endtask

  task automatic test_store();
    build_instr(7, 0);
    build_idle(2);
    run_queue(1000);
    for (int i = 0; i < obsQ.size(); i++) begin
      checks++;
      if ((obsQ[i] & doneQ[i].mask) !== (doneQ[i].exp & doneQ[i].mask)) begin
        errors++;
        $display("[TB] FAIL store cycle %0d: got %b expected %b", i, obsQ[i], doneQ[i].exp);
      end
    end
  endtask

  task automatic test_fetch_idle();
    build_idle(10);
    run_queue(1000);
    for (int i = 0; i < obsQ.size(); i++) begin
      checks++;
      if ((obsQ[i] & doneQ[i].mask) !== (doneQ[i].exp & doneQ[i].mask)) begin
        errors++;
        $display("[TB] FAIL fetch_idle cycle %0d: got %b expected %b", i, obsQ[i], doneQ[i].exp);
      end
    end
  endtask

  task automatic test_illegal();
    build_instr(9, 0);
    if (!TRAP) build_idle(1);
    run_queue(1000);
    for (int i = 0; i < obsQ.size(); i++) begin
      checks++;
      if ((obsQ[i] & doneQ[i].mask) !== (doneQ[i].exp & doneQ[i].mask)) begin
        errors++;
        $display("[TB] FAIL illegal cycle %0d: got %b expected %b", i, obsQ[i], doneQ[i].exp);
      end
    end
    do_reset();
  endtask

  task automatic test_reset_mid_mem();
    build_instr(0, 8);
    run_queue(4);
    for (int i = 0; i < obsQ.size(); i++) begin
      checks++;
      if ((obsQ[i] & doneQ[i].mask) !== (doneQ[i].exp & doneQ[i].mask)) begin
        errors++;
        $display("[TB] FAIL mid_mem_pre cycle %0d: got %b expected %b", i, obsQ[i], doneQ[i].exp);
      end
    end
    bus.memAck = 1'b0;
    #2;
    checks++;
    if (bus.memReq !== 1'b1) begin
      errors++;
      $display("[TB] FAIL mid_mem_req: got %b expected 1", bus.memReq);
    end
    rstN = 1'b0;
    #1;
    checks++;
    if ({bus.memReq, bus.fetchReq, bus.busy} !== 3'b010) begin
      errors++;
      $display("[TB] FAIL mid_mem_reset {memReq,fetchReq,busy}: got %b expected 010",
               {bus.memReq, bus.fetchReq, bus.busy});
    end
    @(negedge clk);
    rstN = 1'b1;
    bus.fetchAck = 1'b0;
    @(posedge clk);
    #1;
    prevOp = 0;
    build_instr(5, 0);
    build_idle(1);
    run_queue(1000);
    for (int i = 0; i < obsQ.size(); i++) begin
      checks++;
      if ((obsQ[i] & doneQ[i].mask) !== (doneQ[i].exp & doneQ[i].mask)) begin
        errors++;
        $display("[TB] FAIL after_mid_reset cycle %0d: got %b expected %b", i, obsQ[i], doneQ[i].exp);
      end
    end
  endtask

  task automatic test_back_to_back();
    int op;
    for (int k = 0; k < 40; k++) begin
      op = TRAP ? int'($urandom_range(0, 7)) : int'($urandom_range(0, 15));
      build_idle(int'($urandom_range(0, 2)));
      build_instr(op, int'($urandom_range(0, 3)));
    end
    build_idle(1);
    run_queue(100000);
    for (int i = 0; i < obsQ.size(); i++) begin
      checks++;
      if ((obsQ[i] & doneQ[i].mask) !== (doneQ[i].exp & doneQ[i].mask)) begin
        errors++;
        $display("[TB] FAIL back_to_back cycle %0d op %0d: got %b expected %b",
                 i, doneQ[i].op, obsQ[i], doneQ[i].exp);
      end
    end
  endtask

  initial begin
    test_reset();
    test_alu_sub();
    test_load_wait();
    test_store();
    test_fetch_idle();
    test_illegal();
    test_reset_mid_mem();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
